// File: rtl/mlp_seq_pkg.sv
// Shared types and default dimensions for the MLP frame sequencer and its helpers.
package mlp_seq_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_RESULT  = 2'd2
    } seq_state_t;

    localparam int unsigned N_FEAT_DEF     = 4;
    localparam int unsigned FEAT_W_DEF     = 4;
    localparam int unsigned CLS_W_DEF      = 2;
    localparam int unsigned SETTLE_CYC_DEF = 2;
    localparam int unsigned SETTLE_W       = 4;
    localparam int unsigned INP_W          = N_FEAT_DEF * FEAT_W_DEF;

endpackage

// File: rtl/mlp_settle_timer.sv
// Loadable down-counter; o_done is high while the count sits at zero.
module mlp_settle_timer
    import mlp_seq_pkg::*;
#(
    parameter int unsigned CNT_W = SETTLE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/mlp_frame_sequencer.sv
// Collects one feature frame for the Balance_Scale MLP, waits for the classifier
// to settle, then returns the captured class over a valid/ready channel.
module mlp_frame_sequencer
    import mlp_seq_pkg::*;
#(
    parameter int unsigned N_FEAT     = N_FEAT_DEF,
    parameter int unsigned FEAT_W     = FEAT_W_DEF,
    parameter int unsigned CLS_W      = CLS_W_DEF,
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     feat_valid,
    output logic                     feat_ready,
    input  logic [FEAT_W-1:0]        feat_data,
    input  logic                     feat_last,
    output logic [N_FEAT*FEAT_W-1:0] clf_inp,
    input  logic [CLS_W-1:0]         clf_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [CLS_W-1:0]         res_class,
    output logic                     frame_err,
    output logic [15:0]              res_count
);

    localparam int unsigned      IDX_W    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

    seq_state_t                r_state;
    seq_state_t                w_state_nxt;
    logic [IDX_W-1:0]          r_idx;
    logic [N_FEAT*FEAT_W-1:0]  r_clf_inp;
    logic                      r_res_valid;
    logic [CLS_W-1:0]          r_res_class;
    logic                      r_frame_err;
    logic [15:0]               r_res_count;

    logic w_accept;
    logic w_complete;
    logic w_early;
    logic w_capture;
    logic w_res_hs;
    logic w_done;

    mlp_settle_timer #(
        .CNT_W (SETTLE_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_complete),
        .i_load_val (SETTLE_W'(SETTLE_CYC - 1)),
        .o_done     (w_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_COLLECT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        w_early     = 1'b0;
        w_capture   = 1'b0;
        w_res_hs    = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                w_accept = feat_valid;
                if (feat_valid) begin
                    if (r_idx == LAST_IDX) begin
                        w_complete  = 1'b1;
                        w_state_nxt = ST_SETTLE;
                    end else if (feat_last) begin
                        w_early = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (w_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    w_res_hs    = 1'b1;
                    w_state_nxt = ST_COLLECT;
                end
            end
            default: w_state_nxt = ST_COLLECT;
        endcase
    end

    // A missing last on the completing feature is flagged but the frame is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_clf_inp   <= '0;
            r_res_valid <= 1'b0;
            r_res_class <= '0;
            r_frame_err <= 1'b0;
            r_res_count <= '0;
        end else begin
            r_frame_err <= w_early | (w_complete & ~feat_last);
            if (w_early) begin
                r_clf_inp <= '0;
                r_idx     <= '0;
            end else if (w_accept) begin
                r_clf_inp[FEAT_W*r_idx +: FEAT_W] <= feat_data;
                r_idx <= w_complete ? '0 : r_idx + 1'b1;
            end
            if (w_capture) begin
                r_res_class <= clf_out;
                r_res_valid <= 1'b1;
            end else if (w_res_hs) begin
                r_res_valid <= 1'b0;
                r_res_count <= r_res_count + 16'd1;
            end
        end
    end

    assign feat_ready = (r_state == ST_COLLECT);
    assign clf_inp    = r_clf_inp;
    assign res_valid  = r_res_valid;
    assign res_class  = r_res_class;
    assign frame_err  = r_frame_err;
    assign res_count  = r_res_count;

endmodule
